vote_tally: RTL and testbench
=============================

# vote_tally

Ballot-capture block for the voting machine: it debounces the four raw candidate buttons and enforces one vote per press. It keeps a saturating 8-bit tally per candidate and pulses `valid_vote_casted` for each accepted vote. It is the producer side of the LED mode-control block and drives that block's `cand*_vote`, `valid_vote_casted` and `cand*_button_press` inputs directly.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required before a debounced level changes (≥1).
- LOCKOUT_CYCLES, 11: cycles spent in LOCKOUT after an accepted vote (≥1); matches the display's LED-on window.

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- mode  in  1  0 = voting, 1 = result display (no counting)
- cand1_btn..cand4_btn  in  1 each  raw asynchronous button inputs, active-high
- cand1_vote..cand4_vote  out  8 each  per-candidate tally
- valid_vote_casted  out  1  one-cycle pulse per accepted vote
- cand1_button_press..cand4_button_press  out  1 each  debounced button levels
- invalid_vote  out  1  one-cycle pulse on a rejected simultaneous press
- busy  out  1  high whenever state ≠ READY

## Operation
- Per button: 2-flop synchronizer, then debounce counter.
  - The debounced level flips only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any agreeing sample clears the counter.
- Let P be the 4-bit vector of debounced levels.
- FSM states: READY, LOCKOUT, WAIT_RELEASE.
- READY:
  - mode=1: stay in READY, count nothing.
  - mode=0, P has exactly one bit set: increment that candidate's tally, assert valid_vote_casted, load lockout counter, go to LOCKOUT.
  - mode=0, P has two or more bits set: assert invalid_vote, tallies unchanged, go to WAIT_RELEASE.
  - P=0: stay in READY.
- LOCKOUT:
  - Ignore all buttons.
  - Leave for WAIT_RELEASE after exactly LOCKOUT_CYCLES cycles.
- WAIT_RELEASE: go to READY on the first cycle with P=0.
- mode is sampled only in READY. A mode change during LOCKOUT or WAIT_RELEASE does not abort the sequence.
- Tally arithmetic is 8-bit unsigned and saturates at 255.
  - A vote for a candidate already at 255 is still accepted: valid_vote_casted pulses, tally stays 255.
  - No wrap to 0.
- Only the debounced edge matters. A button held through LOCKOUT and WAIT_RELEASE never counts twice; it must be released and then re-pressed.
- cand*_button_press reflects P in both modes.

## Timing
- Reset, on the next clk edge: all tallies 0, valid_vote_casted 0, invalid_vote 0, busy 0, cand*_button_press 0, debounce and sync state 0, lockout counter 0, FSM = READY.
- Reset mid-LOCKOUT or mid-debounce returns to READY with tallies cleared, with no pulse emitted.
- Press-to-level latency: a raw input going high and held stable makes the debounced level high DEBOUNCE_CYCLES+2 clock edges after it is first sampled high.
- Vote latency:
  - Vote registered on the edge after P first shows one bit in READY.
  - valid_vote_casted is high for exactly that one following cycle.
  - The incremented tally is visible in that same cycle.
- Spacing and counts:
  - busy goes high in the same cycle as valid_vote_casted.
  - LOCKOUT occupies cycles 1..LOCKOUT_CYCLES counted from the valid_vote_casted cycle.
  - Minimum spacing between two valid_vote_casted pulses is LOCKOUT_CYCLES+2 cycles: lockout, ≥1 WAIT_RELEASE cycle to observe P=0, 1 READY cycle.
- Buttons debouncing in different cycles: the first to reach P wins, and the later one is ignored. Two reaching P on the same edge gives an invalid vote.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=11.
- Reset, then mode=0 and cand2_btn held high 20 cycles → cand2_button_press high 6 edges after first sample; valid_vote_casted one-cycle pulse on the next edge; cand2_vote=1; all other tallies 0; busy high 11+ cycles.
- cand1_btn bouncing (high 3 cycles, low 1, repeated 5×) then held low → no debounced edge, no vote, all tallies 0.
- cand3_btn held 60 cycles continuously → exactly one vote, cand3_vote=1; after release and a clean re-press → cand3_vote=2.
- cand1_btn and cand4_btn raised on the same cycle → invalid_vote single pulse, no valid_vote_casted, tallies unchanged; both released → busy low, READY.
- mode=1 with cand2_btn pressed → cand2_button_press high, no valid_vote_casted, cand2_vote unchanged.
- 256 clean presses of cand4_btn → cand4_vote=255 and 256 valid_vote_casted pulses; reset asserted during the following LOCKOUT → next cycle all tallies 0, busy 0.

Source files
------------

// File: rtl/vote_tally.sv
// Ballot capture: debounces four candidate buttons, accepts one vote per clean press,
// and keeps a saturating 8-bit tally per candidate.
module vote_tally #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LOCKOUT_CYCLES  = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic       cand1_btn,
    input  logic       cand2_btn,
    input  logic       cand3_btn,
    input  logic       cand4_btn,
    output logic [7:0] cand1_vote,
    output logic [7:0] cand2_vote,
    output logic [7:0] cand3_vote,
    output logic [7:0] cand4_vote,
    output logic       valid_vote_casted,
    output logic       cand1_button_press,
    output logic       cand2_button_press,
    output logic       cand3_button_press,
    output logic       cand4_button_press,
    output logic       invalid_vote,
    output logic       busy,
    output logic [1:0] o_dbg_state
);

    localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LK_W = (LOCKOUT_CYCLES < 2) ? 1 : $clog2(LOCKOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_READY        = 2'd0,
        ST_LOCKOUT      = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } state_t;

    logic [3:0]      w_raw;
    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [3:0]      r_level;
    logic [DB_W-1:0] r_db_cnt [4];

    state_t          r_state;
    state_t          w_next_state;
    logic [LK_W-1:0] r_lock_cnt;
    logic            w_one_hot;
    logic            w_multi;
    logic            w_accept;
    logic            w_reject;

    logic [7:0]      r_tally [4];
    logic            r_valid;
    logic            r_invalid;
    logic            r_busy;

    assign w_raw = {cand4_btn, cand3_btn, cand2_btn, cand1_btn};

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_level[i]  <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_one_hot = (r_level != 4'd0) && ((r_level & (r_level - 4'd1)) == 4'd0);
    assign w_multi   = (r_level != 4'd0) && !w_one_hot;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            ST_READY: begin
                if (!mode && w_one_hot) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_LOCKOUT;
                end else if (!mode && w_multi) begin
                    w_reject     = 1'b1;
                    w_next_state = ST_WAIT_RELEASE;
                end
            end
            ST_LOCKOUT: begin
                if (r_lock_cnt == '0) w_next_state = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (r_level == 4'd0) w_next_state = ST_READY;
            end
            default: w_next_state = ST_READY;
        endcase
    end

    // valid_vote_casted / invalid_vote are single-cycle pulses with no back-pressure;
    // the consumer must sample them every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_READY;
            r_lock_cnt <= '0;
            r_valid    <= 1'b0;
            r_invalid  <= 1'b0;
            r_busy     <= 1'b0;
            for (int i = 0; i < 4; i++) r_tally[i] <= '0;
        end else begin
            r_state   <= w_next_state;
            r_valid   <= w_accept;
            r_invalid <= w_reject;
            r_busy    <= (w_next_state != ST_READY);
            if (w_accept) begin
                r_lock_cnt <= LK_W'(LOCKOUT_CYCLES - 1);
            end else if (r_state == ST_LOCKOUT && r_lock_cnt != '0) begin
                r_lock_cnt <= r_lock_cnt - 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (w_accept && r_level[i] && r_tally[i] != 8'hFF) begin
                    r_tally[i] <= r_tally[i] + 8'd1;
                end
            end
        end
    end

    assign cand1_vote         = r_tally[0];
    assign cand2_vote         = r_tally[1];
    assign cand3_vote         = r_tally[2];
    assign cand4_vote         = r_tally[3];
    assign cand1_button_press = r_level[0];
    assign cand2_button_press = r_level[1];
    assign cand3_button_press = r_level[2];
    assign cand4_button_press = r_level[3];
    assign valid_vote_casted  = r_valid;
    assign invalid_vote       = r_invalid;
    assign busy               = r_busy;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_vote_tally.sv
// Bench for vote_tally: table-driven press vectors, directed latency/bounce/saturation
// sequences, and a pulse scoreboard fed from a model of the tallies.
module tb_vote_tally;

    localparam int DB = 4;
    localparam int LK = 11;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] btn = 4'd0;
    logic [7:0] v1, v2, v3, v4;
    logic       valid, invalid, busy;
    logic       p1, p2, p3, p4;
    logic [1:0] dbg_state;
    logic [3:0] press;
    logic [31:0] dut_tallies;

    assign press       = {p4, p3, p2, p1};
    assign dut_tallies = {v4, v3, v2, v1};

    vote_tally #(.DEBOUNCE_CYCLES(DB), .LOCKOUT_CYCLES(LK)) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .cand1_btn(btn[0]), .cand2_btn(btn[1]), .cand3_btn(btn[2]), .cand4_btn(btn[3]),
        .cand1_vote(v1), .cand2_vote(v2), .cand3_vote(v3), .cand4_vote(v4),
        .valid_vote_casted(valid),
        .cand1_button_press(p1), .cand2_button_press(p2),
        .cand3_button_press(p3), .cand4_button_press(p4),
        .invalid_vote(invalid), .busy(busy), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    logic [7:0]  m_tally [4];
    logic [33:0] exp_q [$];

    function automatic logic [31:0] model_tallies();
        return {m_tally[3], m_tally[2], m_tally[1], m_tally[0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_valid(input logic [3:0] b);
        for (int i = 0; i < 4; i++)
            if (b[i] && m_tally[i] != 8'hFF) m_tally[i] = m_tally[i] + 8'd1;
        exp_q.push_back({2'b10, model_tallies()});
    endtask

    // Scoreboard: every pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (valid || invalid) begin
            if (valid) n_valid++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_pulse: got valid=%0b invalid=%0b tallies=%h expected no pulse",
                         valid, invalid, dut_tallies);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                if ({valid, invalid, dut_tallies} !== e) begin
                    n_errors++;
                    $display("FAIL pulse: got %h expected %h", {valid, invalid, dut_tallies}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        btn   = 4'd0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) m_tally[i] = 8'd0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || press != 4'd0) && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", {62'd0, busy, (press != 4'd0)}, 64'd0);
    endtask

    typedef struct {
        logic [3:0] btns;
        logic       mode;
        int         hold;
        logic       exp_valid;
        logic       exp_invalid;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int busy_cnt;
        int seen_hi;
        int start_valid;
        int n;

        vecs[0] = '{4'b0100, 1'b0, 60, 1'b1, 1'b0};
        vecs[1] = '{4'b0100, 1'b0, 10, 1'b1, 1'b0};
        vecs[2] = '{4'b1001, 1'b0, 10, 1'b0, 1'b1};
        vecs[3] = '{4'b0010, 1'b1, 10, 1'b0, 1'b0};
        vecs[4] = '{4'b0001, 1'b0,  8, 1'b1, 1'b0};
        vecs[5] = '{4'b1110, 1'b0, 10, 1'b0, 1'b1};
        vecs[6] = '{4'b0011, 1'b1, 10, 1'b0, 1'b0};
        vecs[7] = '{4'b1000, 1'b0,  8, 1'b1, 1'b0};

        do_reset();
        check("reset_tallies", {32'd0, dut_tallies}, 64'd0);
        check("reset_flags", {59'd0, valid, invalid, busy, (press != 4'd0), (dbg_state != 2'd0)}, 64'd0);

        // Press latency: level on the 6th edge, vote pulse on the 7th.
        mode = 1'b0;
        btn  = 4'b0010;
        busy_cnt = 0;
        for (int e = 1; e <= 20; e++) begin
            if (e == 7) push_valid(4'b0010);
            tick();
            if (busy) busy_cnt++;
            if (e == 5) check("press_before_lat", {63'd0, p2}, 64'd0);
            if (e == 6) check("press_at_lat", {62'd0, p2, valid}, 64'd2);
            if (e == 7) begin
                check("vote_pulse", {62'd0, valid, busy}, 64'd3);
                check("vote_tally", {32'd0, dut_tallies}, {32'd0, 8'd0, 8'd0, 8'd1, 8'd0});
            end
            if (e == 8) check("pulse_one_cycle", {63'd0, valid}, 64'd0);
        end
        check("busy_span", {63'd0, (busy_cnt >= LK)}, 64'd1);
        btn = 4'd0;
        wait_idle(60);

        // Bouncing cand1 never reaches DB consecutive samples.
        seen_hi = 0;
        for (int r = 0; r < 5; r++) begin
            btn[0] = 1'b1;
            repeat (3) begin tick(); if (p1) seen_hi = 1; end
            btn[0] = 1'b0;
            tick();
            if (p1) seen_hi = 1;
        end
        repeat (10) begin tick(); if (p1) seen_hi = 1; end
        check("bounce_no_level", seen_hi, 0);
        check("bounce_tallies", {32'd0, dut_tallies}, {32'd0, model_tallies()});

        for (int k = 0; k < 8; k++) begin
            if (vecs[k].exp_valid) push_valid(vecs[k].btns);
            if (vecs[k].exp_invalid) exp_q.push_back({2'b01, model_tallies()});
            mode = vecs[k].mode;
            btn  = vecs[k].btns;
            repeat (vecs[k].hold) tick();
            check($sformatf("vec%0d_press", k), {60'd0, press}, {60'd0, vecs[k].btns});
            btn = 4'd0;
            wait_idle(60);
            mode = 1'b0;
            check($sformatf("vec%0d_tallies", k), {32'd0, dut_tallies}, {32'd0, model_tallies()});
        end

        // First debounced button wins; the later one is ignored.
        push_valid(4'b0001);
        btn = 4'b0001;
        tick();
        tick();
        btn = 4'b0011;
        repeat (12) tick();
        btn = 4'd0;
        wait_idle(60);
        check("first_wins", {32'd0, dut_tallies}, {32'd0, model_tallies()});

        // Saturation from a clean reset.
        do_reset();
        start_valid = n_valid;
        for (int k = 0; k < 256; k++) begin
            push_valid(4'b1000);
            btn = 4'b1000;
            repeat (8) tick();
            btn = 4'd0;
            wait_idle(60);
        end
        check("sat_tally", {56'd0, v4}, 64'd255);
        check("sat_pulses", n_valid - start_valid, 256);

        // Vote at 255 still pulses; reset during its lockout clears everything.
        push_valid(4'b1000);
        btn = 4'b1000;
        n = 0;
        while (!valid && n < 20) begin
            tick();
            n++;
        end
        check("sat_extra_pulse", {63'd0, valid}, 64'd1);
        check("sat_extra_tally", {56'd0, v4}, 64'd255);
        reset = 1'b1;
        btn   = 4'd0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) m_tally[i] = 8'd0;
        check("midreset_tallies", {32'd0, dut_tallies}, 64'd0);
        check("midreset_flags", {60'd0, valid, invalid, busy, (press != 4'd0)}, 64'd0);
        repeat (20) tick();
        check("midreset_idle", {62'd0, busy, valid}, 64'd0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
